// File: rtl/ama_riscv_spec_tracker_pkg.sv
// Speculation tracker shared types.
// Queue entry layout and reset constant.
package ama_riscv_spec_tracker_pkg;

  localparam int ARCH_W = 32;

  typedef logic [ARCH_W-1:0] arch_width_t;

  typedef enum logic {
    B_NT = 1'b0,
    B_T  = 1'b1
  } branch_t;

  typedef struct packed {
    arch_width_t pc;
    branch_t     pred;
  } spec_q_entry_t;

  localparam spec_q_entry_t SPEC_Q_ENTRY_RST = '{
    pc:   'h0,
    pred: B_NT
  };

  localparam int SPEC_Q_ENTRY_W = $bits(spec_q_entry_t);

endpackage

// File: rtl/ama_riscv_spec_fifo.sv
// Generic circular buffer with push/pop/flush.
// Flush empties the queue and discards a same-cycle push.
module ama_riscv_spec_fifo #(
  parameter int         DEPTH   = 4,
  parameter int         W       = 33,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ama_riscv_spec_tracker.sv
// In-order tracker of unresolved predicted branches.
// Optional stats counters: AMA_RISCV_SPEC_STATS_EN.
module ama_riscv_spec_tracker
  import ama_riscv_spec_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enq_valid,
  input  logic [PC_W-1:0]        enq_pc,
  input  logic                   enq_pred,
  output logic                   enq_ready,
  input  logic                   res_valid,
  input  logic [PC_W-1:0]        res_pc,
  input  logic                   res_taken,
  output logic                   hit,
  output logic                   wrong,
  output logic [PC_W-1:0]        cp_pc,
  output logic                   cp_taken,
  output logic                   spec_active,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  localparam int EW = PC_W + 1;
  localparam logic [EW-1:0] ENT_RST =
    EW'(SPEC_Q_ENTRY_RST);

  logic [EW-1:0]   head;
  logic [PC_W-1:0] head_pc;
  logic            head_pred;
  logic            full;
  logic            match;
  logic            push;

  assign head_pc   = head[EW-1:1];
  assign head_pred = head[0];

  assign match = res_valid
              && (count != '0)
              && (res_pc == head_pc);
  assign hit   = match && (head_pred == res_taken);
  assign wrong = match && (head_pred != res_taken);

  assign enq_ready   = !full || hit;
  assign push        = enq_valid && enq_ready && !wrong;
  assign cp_pc       = head_pc;
  assign cp_taken    = res_taken;
  assign spec_active = (count != '0);

  ama_riscv_spec_fifo #(
    .DEPTH   (DEPTH),
    .W       (EW),
    .RST_VAL (ENT_RST)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (hit),
    .flush (wrong),
    .din   ({enq_pc, enq_pred}),
    .head  (head),
    .count (count),
    .full  (full)
  );

  // Sticky flag for a push offered while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (enq_valid && !enq_ready) begin
      err <= 1'b1;
    end
  end

`ifdef AMA_RISCV_SPEC_STATS_EN
  // Saturating hit/mispredict statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (wrong && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
